// File: rtl/q_episode_ctrl.sv
// q_episode_ctrl: episode/step sequencer for the Q-learning datapath.
// Issues one step request per transition, tracks steps and episodes, ends an
// episode on the goal state or the step cap, and decays the exploration
// threshold once per completed episode.
module q_episode_ctrl #(
    parameter int STATES_WIDTH = 4,
    parameter int GOAL_STATE   = 15,
    parameter int MAX_STEPS    = 64,
    parameter int NUM_EPISODES = 100,
    parameter int STEP_WIDTH   = 8,
    parameter int EP_WIDTH     = 16,
    parameter int EPS_INIT     = 200,
    parameter int EPS_DEC      = 10,
    parameter int EPS_MIN      = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    input  logic                    i_start,
    input  logic [STATES_WIDTH-1:0] i_first_st,
    input  logic                    i_step_done,
    input  logic [STATES_WIDTH-1:0] i_next_st,
    output logic                    o_step_req,
    output logic [STATES_WIDTH-1:0] o_cur_st,
    output logic                    o_explore,
    output logic [STEP_WIDTH-1:0]   o_step_cnt,
    output logic [EP_WIDTH-1:0]     o_episode_cnt,
    output logic                    o_busy,
    output logic                    o_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [STATES_WIDTH-1:0] GOAL_ST   = STATES_WIDTH'(GOAL_STATE);
    localparam logic [STEP_WIDTH-1:0]   STEP_CAP  = STEP_WIDTH'(MAX_STEPS);
    localparam logic [EP_WIDTH-1:0]     EP_LAST   = EP_WIDTH'(NUM_EPISODES);
    localparam logic [7:0]              EPS_INIT8 = 8'(EPS_INIT);
    localparam logic [7:0]              EPS_MIN8  = 8'(EPS_MIN);
    localparam logic [8:0]              EPS_DEC9  = 9'(EPS_DEC);
    localparam logic [8:0]              EPS_FLOOR = 9'(EPS_MIN + EPS_DEC);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [STATES_WIDTH-1:0] r_first_st;
    logic [STATES_WIDTH-1:0] r_cur_st;
    logic [STATES_WIDTH-1:0] r_next_st;
    logic [STEP_WIDTH-1:0]   r_step_cnt;
    logic [EP_WIDTH-1:0]     r_ep_cnt;
    logic [7:0]              r_eps;
    logic [7:0]              r_lfsr;
    logic                    r_busy;
    logic                    r_valid;

    logic                    w_start;
    logic                    w_ep_end;
    logic [EP_WIDTH-1:0]     w_ep_cnt_inc;
    logic                    w_last_ep;
    logic [8:0]              w_eps_wide;
    logic [7:0]              w_eps_next;
    logic                    w_lfsr_fb;

    assign w_start      = i_valid & i_start;
    assign w_ep_end     = (r_next_st == GOAL_ST) || (r_step_cnt == STEP_CAP);
    assign w_ep_cnt_inc = r_ep_cnt + EP_WIDTH'(1);
    assign w_last_ep    = (w_ep_cnt_inc == EP_LAST);
    // Threshold decay is done at 9 bits so the subtraction can never wrap.
    assign w_eps_wide   = {1'b0, r_eps};
    assign w_eps_next   = (w_eps_wide >= EPS_FLOOR) ? 8'(w_eps_wide - EPS_DEC9) : EPS_MIN8;
    // Fibonacci feedback from taps 8,6,5,4 (1-based), shifted in at bit 0.
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    assign o_cur_st      = r_cur_st;
    assign o_step_cnt    = r_step_cnt;
    assign o_episode_cnt = r_ep_cnt;
    assign o_busy        = r_busy;
    assign o_valid       = r_valid;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection plus the single-cycle step request and explore flag.
    always_comb begin
        w_state_next = r_state;
        o_step_req   = 1'b0;
        o_explore    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                o_step_req   = 1'b1;
                o_explore    = (r_lfsr < r_eps);
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_step_done) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (!w_ep_end) begin
                    w_state_next = S_ISSUE;
                end else if (w_last_ep) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_LOAD;
                end
            end
            S_DONE: begin
                if (w_start) w_state_next = S_LOAD;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers: start latch, counters, threshold, LFSR and run flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_first_st <= '0;
            r_cur_st   <= '0;
            r_next_st  <= '0;
            r_step_cnt <= '0;
            r_ep_cnt   <= '0;
            r_eps      <= EPS_INIT8;
            r_lfsr     <= 8'hA5;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_first_st <= i_first_st;
                        r_ep_cnt   <= '0;
                        r_eps      <= EPS_INIT8;
                        r_busy     <= 1'b1;
                        r_valid    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_cur_st   <= r_first_st;
                    r_step_cnt <= '0;
                end
                S_ISSUE: begin
                    r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
                end
                S_WAIT: begin
                    if (i_step_done) begin
                        r_next_st  <= i_next_st;
                        r_step_cnt <= r_step_cnt + STEP_WIDTH'(1);
                    end
                end
                S_CHECK: begin
                    if (w_ep_end) begin
                        r_ep_cnt <= w_ep_cnt_inc;
                        r_eps    <= w_eps_next;
                        if (w_last_ep) begin
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                        end
                    end else begin
                        r_cur_st <= r_next_st;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/q_episode_ctrl.md
Name: q_episode_ctrl

Overview:
Episode/step sequencer for the Q-learning datapath. It latches the first state on start and issues one step request per transition to the action-select/Q-update datapath. It tracks steps and episodes, ends an episode on the goal state or the step cap, and decays the exploration threshold per episode. It drives the top-level completion flag o_valid.

Parameters:
STATES_WIDTH, 4, state index width (matches params.sv)
GOAL_STATE, 15, terminal state index
MAX_STEPS, 64, step cap per episode (1..2^STEP_WIDTH-1)
NUM_EPISODES, 100, episodes per run (>=1)
STEP_WIDTH, 8, step counter width
EP_WIDTH, 16, episode counter width
EPS_INIT, 200, initial exploration threshold (0..255)
EPS_DEC, 10, threshold decrement per episode
EPS_MIN, 20, threshold floor

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
i_valid  in  1  qualifies i_start/i_first_st
i_start  in  1  start request
i_first_st  in  STATES_WIDTH  start state of every episode
i_step_done  in  1  datapath finished the current step (1-cycle pulse)
i_next_st  in  STATES_WIDTH  resulting state, valid with i_step_done
o_step_req  out  1  1-cycle pulse: datapath performs one step
o_cur_st  out  STATES_WIDTH  current state, stable from o_step_req until i_step_done
o_explore  out  1  random-action select, valid with o_step_req
o_step_cnt  out  STEP_WIDTH  steps completed in current episode
o_episode_cnt  out  EP_WIDTH  episodes completed
o_busy  out  1  run in progress
o_valid  out  1  run complete, held high

Behaviour:
- Reset (rst_n=0 at posedge, any state): FSM->IDLE. All outputs 0. eps=EPS_INIT. LFSR=8'hA5. A reset mid-episode abandons the step; a late i_step_done is ignored.
- FSM states: IDLE, LOAD, ISSUE, WAIT, CHECK, DONE.
- IDLE: on i_valid&i_start, latch first_st, clear ep_cnt, set eps=EPS_INIT and o_busy=1, go to LOAD.
- LOAD: cur_st<=first_st, step_cnt<=0, go to ISSUE.
- ISSUE: o_step_req=1 for exactly this cycle. o_explore=(lfsr<eps) uses the pre-advance LFSR value. LFSR advances once (Fibonacci, taps 8,6,5,4, shift left, feedback into bit0). Go to WAIT.
- WAIT: hold o_cur_st. On i_step_done, capture i_next_st and set step_cnt+=1, then go to CHECK. Otherwise stay; there is no timeout.
- CHECK, episode end (next==GOAL_STATE or step_cnt==MAX_STEPS):
  - ep_cnt+=1.
  - eps = (eps >= EPS_MIN+EPS_DEC) ? eps-EPS_DEC : EPS_MIN. Compute at 9 bits; no underflow.
  - If new ep_cnt==NUM_EPISODES go to DONE, else go to LOAD.
- CHECK, episode continues: cur_st<=next, go to ISSUE.
- DONE: o_valid=1, o_busy=0. o_episode_cnt and o_step_cnt hold their final values. On i_valid&i_start, clear o_valid and restart as from IDLE with the new i_first_st.
- Latency: start accepted at edge N gives o_step_req high in cycle N+2. i_step_done at edge M gives the next o_step_req in cycle M+2 when the episode continues, or M+3 across an episode boundary.
- i_start while busy: ignored. i_start without i_valid: ignored.
- i_step_done outside WAIT: ignored, no state change.
- i_first_st==GOAL_STATE: at least one step is still issued; the goal check applies only to i_next_st.
- o_step_cnt resets to 0 in LOAD; the counter never wraps because MAX_STEPS < 2^STEP_WIDTH.

Test Plan:
- Goal run: GOAL=15, NUM_EPISODES=3, first_st=0; datapath model returns next=cur+1 after 2 cycles -> 15 step_req per episode, o_cur_st 0..14; o_valid rises after episode 3 with o_episode_cnt=3, o_step_cnt=15.
- Step cap: model returns next=cur (never goal), MAX_STEPS=64, NUM_EPISODES=2 -> exactly 128 step_req; o_valid with o_step_cnt=64.
- Epsilon decay: EPS_INIT=200, EPS_DEC=50, EPS_MIN=20, 6 episodes -> threshold per episode 200,150,100,50,20,20. Check o_explore against a reference LFSR seeded 8'hA5.
- Protocol abuse: i_start pulse while in WAIT and i_step_done pulse during ISSUE -> no restart, step_cnt unchanged; start with i_valid=0 in IDLE -> stays idle.
- Reset mid-run: rst_n low for 1 cycle during WAIT in episode 2 -> all outputs 0 next cycle; a fresh start replays the identical step_req/o_explore sequence.
- Restart from DONE: i_valid&i_start with first_st=5 -> o_valid drops, first step_req 2 cycles later with o_cur_st=5, o_episode_cnt=0.
